// File: rtl/weight_fetch_fc_seq.sv
// Self-sequencing FC-layer weight fetch: COLS banks streamed one row per beat
// through a 2-entry valid/ready FIFO, with zero-masking of unused columns.
module weight_fetch_fc_seq #(
    parameter int DW    = 8,
    parameter int COLS  = 4,
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(COLS)-1:0]  wr_bank,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     start,
    input  logic [CW-1:0]            cfg_kernel_num,
    input  logic [CW-1:0]            cfg_kernel_len,
    input  logic [AW-1:0]            cfg_base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW*COLS-1:0]       out_data,
    output logic                     out_last,
    output logic                     out_grp_last
);

    localparam int BW = $clog2(COLS);
    localparam int LW = CW + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    state_t              state;
    logic [CW-1:0]       num_q;
    logic [CW-1:0]       len_q;
    logic [AW-1:0]       addr_q;
    logic [CW-1:0]       k_q;
    logic [LW-1:0]       lane_base;

    logic                rd_v;
    logic [COLS-1:0]     rd_mask;
    logic                rd_last;
    logic                rd_grp;
    logic [DW*COLS-1:0]  rd_masked;

    logic [DW*COLS-1:0]  fifo_data [2];
    logic                fifo_last [2];
    logic                fifo_grp  [2];
    logic                wptr;
    logic                rptr;
    logic [1:0]          count;

    logic [COLS-1:0]     lane_en;
    logic                last_grp;
    logic                k_end;
    logic                push;
    logic                pop;
    logic                issue;

    assign out_valid    = (count != 2'd0);
    assign out_data     = fifo_data[rptr];
    assign out_last     = fifo_last[rptr];
    assign out_grp_last = fifo_grp[rptr];

    assign pop      = out_valid && out_ready;
    assign push     = rd_v;
    assign k_end    = (k_q == len_q - 1'b1);
    assign last_grp = (lane_base + LW'(COLS)) >= {2'b00, num_q};

    // A same-cycle pop frees a slot, which keeps the stream at one beat per cycle.
    assign issue = (state == FETCH) &&
                   (({1'b0, count} + {2'b00, rd_v}) < (3'd2 + {2'b00, pop}));

    for (genvar c = 0; c < COLS; c++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] q;

        assign lane_en[c] = (lane_base + LW'(c)) < {2'b00, num_q};

        always_ff @(posedge clk) begin
            if (wr_en && wr_bank == BW'(c))
                mem[wr_addr] <= wr_data;
            if (issue && lane_en[c])
                q <= mem[addr_q];
        end

        assign rd_masked[DW*c +: DW] = rd_mask[c] ? q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            num_q        <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            k_q          <= '0;
            lane_base    <= '0;
            rd_v         <= 1'b0;
            rd_mask      <= '0;
            rd_last      <= 1'b0;
            rd_grp       <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            fifo_grp[0]  <= 1'b0;
            fifo_grp[1]  <= 1'b0;
            wptr         <= 1'b0;
            rptr         <= 1'b0;
            count        <= 2'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            rd_v <= issue;
            if (issue) begin
                rd_mask <= lane_en;
                rd_last <= k_end && last_grp;
                rd_grp  <= k_end;
            end

            if (push) begin
                fifo_data[wptr] <= rd_masked;
                fifo_last[wptr] <= rd_last;
                fifo_grp[wptr]  <= rd_grp;
                wptr            <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};

            unique case (state)
                IDLE: begin
                    if (start) begin
                        num_q     <= cfg_kernel_num;
                        len_q     <= cfg_kernel_len;
                        addr_q    <= cfg_base_addr;
                        k_q       <= '0;
                        lane_base <= '0;
                        busy      <= 1'b1;
                        if (cfg_kernel_num == '0 || cfg_kernel_len == '0)
                            state <= FIN;
                        else
                            state <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        // Address is base + g*len + k, i.e. a plain running count.
                        addr_q <= addr_q + 1'b1;
                        if (k_end) begin
                            k_q       <= '0;
                            lane_base <= lane_base + LW'(COLS);
                            if (last_grp)
                                state <= DRAIN;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (count == 2'd0 && !rd_v)
                        state <= FIN;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_fc_seq.sv
// Bench for weight_fetch_fc_seq: directed layers plus randomized layers and
// backpressure, checked against an array/queue model of the layer stream.
module tb_weight_fetch_fc_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [9:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic [15:0] cfg_kernel_num = '0;
    logic [15:0] cfg_kernel_len = '0;
    logic [9:0]  cfg_base_addr = '0;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_grp_last;

    weight_fetch_fc_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .start          (start),
        .cfg_kernel_num (cfg_kernel_num),
        .cfg_kernel_len (cfg_kernel_len),
        .cfg_base_addr  (cfg_base_addr),
        .busy           (busy),
        .done           (done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_grp_last   (out_grp_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        grp;
    } beat_t;

    logic [7:0] mem_m [4][1024];
    beat_t      exp_q [$];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int b, input int a, input int d);
        wr_en   = 1'b1;
        wr_bank = 2'(b);
        wr_addr = 10'(a);
        wr_data = 8'(d);
        mem_m[b][a] = 8'(d);
        step();
        wr_en = 1'b0;
    endtask

    // Layer = ceil(num/4) groups of len beats; lane c of group g is kernel 4g+c.
    task automatic build_exp(input int num, input int len, input int base);
        int    grps;
        beat_t b;
        exp_q.delete();
        grps = (num + 3) / 4;
        if (num == 0 || len == 0) return;
        for (int g = 0; g < grps; g++) begin
            for (int k = 0; k < len; k++) begin
                int a;
                a = (base + g * len + k) % 1024;
                b.data = '0;
                for (int c = 0; c < 4; c++)
                    if (g * 4 + c < num) b.data[8*c +: 8] = mem_m[c][a];
                b.last = (g == grps - 1) && (k == len - 1);
                b.grp  = (k == len - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // mode: 0 ready high, 1 ready 1,0,0,1 pattern, 2 random ready.
    task automatic run_layer(input string nm, input int num, input int len,
                             input int base, input int mode,
                             input bit inject, input bit abort);
        int          beat;
        int          cyc;
        bit          got_done;
        bit          stall;
        logic [31:0] hold_d;
        logic        hold_l;
        logic        hold_g;
        logic        rdy;
        build_exp(num, len, base);
        cfg_kernel_num = 16'(num);
        cfg_kernel_len = 16'(len);
        cfg_base_addr  = 10'(base);
        start = 1'b1;
        step();
        start = 1'b0;
        beat = 0;
        cyc = 0;
        got_done = 0;
        stall = 0;
        while (!got_done && cyc < 400) begin
            if (abort && beat == 3) begin
                rst_n = 1'b0;
                #1;
                chk({nm, "_rst_valid"}, out_valid, 0);
                chk({nm, "_rst_busy"}, busy, 0);
                chk({nm, "_rst_data"}, out_data, 0);
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk({nm, "_rst_done"}, done, 0);
                end
                rst_n = 1'b1;
                step();
                chk({nm, "_post_rst_busy"}, busy, 0);
                return;
            end
            if (done) begin
                got_done = 1;
                break;
            end
            chk({nm, "_busy"}, busy, 1);
            if (stall) begin
                chk({nm, "_stall_valid"}, out_valid, 1);
                chk({nm, "_stall_data"}, out_data, hold_d);
                chk({nm, "_stall_last"}, out_last, hold_l);
                chk({nm, "_stall_grp"}, out_grp_last, hold_g);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (inject && cyc == 4) begin
                start = 1'b1;
                cfg_kernel_num = 16'd2;
            end else begin
                start = 1'b0;
            end
            if (out_valid && rdy) begin
                if (beat >= exp_q.size()) begin
                    chk({nm, "_extra_beat"}, beat, exp_q.size());
                end else begin
                    chk({nm, "_data"}, out_data, exp_q[beat].data);
                    chk({nm, "_last"}, out_last, exp_q[beat].last);
                    chk({nm, "_grp"}, out_grp_last, exp_q[beat].grp);
                end
                beat++;
            end
            stall  = out_valid && !rdy;
            hold_d = out_data;
            hold_l = out_last;
            hold_g = out_grp_last;
            step();
            cyc++;
        end
        start = 1'b0;
        cfg_kernel_num = 16'(num);
        chk({nm, "_done_seen"}, got_done, 1);
        if (!got_done) return;
        chk({nm, "_beats"}, beat, exp_q.size());
        chk({nm, "_busy_clear"}, busy, 0);
        chk({nm, "_valid_clear"}, out_valid, 0);
        if (exp_q.size() == 0)
            chk({nm, "_zero_latency_ok"}, cyc <= 3, 1);
        step();
        chk({nm, "_done_pulse"}, done, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_last", out_last, 0);
        chk("reset_grp", out_grp_last, 0);
        rst_n = 1'b1;
        step();

        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 1024; a++)
                wr(b, a, (16 * b + a) & 255);

        run_layer("basic", 6, 3, 0, 0, 0, 0);
        run_layer("toggle", 6, 3, 0, 1, 0, 0);
        run_layer("num0", 0, 3, 0, 0, 0, 0);
        run_layer("len0", 6, 0, 0, 0, 0, 0);
        run_layer("restart", 6, 3, 0, 0, 1, 0);
        run_layer("abort", 6, 3, 0, 0, 0, 1);
        run_layer("rerun", 6, 3, 0, 0, 0, 0);
        run_layer("wrap", 4, 4, 1022, 0, 0, 0);
        run_layer("wrap_rand", 9, 5, 1020, 2, 0, 0);

        for (int t = 0; t < 10; t++) begin
            for (int w = 0; w < 4; w++)
                wr($urandom_range(0, 3), $urandom_range(0, 1023),
                   $urandom_range(0, 255));
            run_layer("rand", $urandom_range(0, 13), $urandom_range(0, 6),
                      $urandom_range(0, 1023), 2, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
